uart_tx_ctrl: RTL and testbench

- UART transmit controller: frame FSM, serializer and output mux for the TX path.
- Consumes the registered parity bit from the TX parity calculator and drives the serial line and the shared Busy flag.
- Busy feeds back to the parity calculator, so both blocks capture the same P_DATA word on the same accept edge.
- One CLK cycle per bit; CLK is the baud-rate clock.

---
 rtl/uart_tx_ctrl.sv | 115 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frame sequencing (start, data LSB first, optional parity, stop),
// serialisation and the registered TX line / Busy flag shared with the parity calculator.
module uart_tx_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             parity_enable,
  input  logic             parity,
  output logic             TX_OUT,
  output logic             Busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_en_q, par_en_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      par_en_q <= par_en_d;
    end
  end

  // The shift register is pre-shifted on the START edge, so during DATA the
  // next bit to present is always shift_q[0].
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    par_en_d = par_en_q;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (Data_Valid && !busy_q) begin
          shift_d  = P_DATA;
          par_en_d = parity_enable;
          state_d  = START;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = parity;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frame-level queue model checked every cycle, plus literal frame checks.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       parity_enable;
  logic       par;
  logic       par_odd;
  logic       TX_OUT;
  logic       Busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.WIDTH(8)) dut (
    .CLK           (clk),
    .RST           (rst_n),
    .P_DATA        (P_DATA),
    .Data_Valid    (Data_Valid),
    .parity_enable (parity_enable),
    .parity        (par),
    .TX_OUT        (TX_OUT),
    .Busy          (Busy)
  );

  // Parity calculator stand-in: word captured on accept, parity registered one edge later.
  logic [7:0] pc_data;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_data <= '0;
      par     <= 1'b0;
    end else begin
      if (Data_Valid && !Busy) pc_data <= P_DATA;
      par <= (^pc_data) ^ par_odd;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Model: on accept, the whole frame is expanded into a queue of (tx, busy) cycles.
  logic       exp_tx = 1'b1;
  logic       exp_busy = 1'b0;
  logic [1:0] fq[$];
  always @(posedge clk or negedge rst_n) begin
    logic [1:0] e;
    if (!rst_n) begin
      fq.delete();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end else begin
      if (!exp_busy && Data_Valid) begin
        fq.push_back(2'b01);
        for (int i = 0; i < 8; i++) fq.push_back({P_DATA[i], 1'b1});
        if (parity_enable) fq.push_back({(^P_DATA) ^ par_odd, 1'b1});
        fq.push_back(2'b11);
      end
      if (fq.size() > 0) begin
        e = fq.pop_front();
        exp_tx   = e[1];
        exp_busy = e[0];
      end else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_tx", {31'd0, TX_OUT}, {31'd0, exp_tx});
    chk("model_busy", {31'd0, Busy}, {31'd0, exp_busy});
  end

  task automatic send_frame(input string name, input logic [7:0] d, input logic pe,
                            input logic odd, input int n, input logic [15:0] exp_seq);
    logic [15:0] seq;
    int bc;
    @(negedge clk);
    P_DATA = d; parity_enable = pe; par_odd = odd; Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0;
    seq = '0;
    bc = 0;
    for (int i = 0; i < n + 3; i++) begin
      if (i < n) seq = {seq[14:0], TX_OUT};
      bc += int'(Busy);
      @(negedge clk);
    end
    chk({name, "_seq"}, {16'd0, seq}, {16'd0, exp_seq});
    chk({name, "_busy_len"}, bc, n);
  endtask

  initial begin
    int idle_ok, idle_cnt, busy1;
    logic seen_rise;
    rst_n = 1'b0; Data_Valid = 1'b0; P_DATA = '0; parity_enable = 1'b0; par_odd = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, TX_OUT}, 32'd1);
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    rst_n = 1'b1;

    idle_ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (TX_OUT === 1'b1 && Busy === 1'b0) idle_ok++;
    end
    chk("idle_20", idle_ok, 20);

    send_frame("a5_even", 8'hA5, 1'b1, 1'b0, 11, 16'b01010010101);
    send_frame("01_odd",  8'h01, 1'b1, 1'b1, 11, 16'b01000000001);
    send_frame("01_even", 8'h01, 1'b1, 1'b0, 11, 16'b01000000011);
    send_frame("3c_nopar", 8'h3C, 1'b0, 1'b0, 10, 16'b0001111001);

    // Data_Valid held high, P_DATA and parity_enable churning every cycle.
    @(negedge clk);
    P_DATA = 8'h3C; parity_enable = 1'b0; par_odd = 1'b0; Data_Valid = 1'b1;
    idle_cnt = 0; busy1 = 0; seen_rise = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!seen_rise) begin
        if (!Busy) idle_cnt++;
        else if (idle_cnt > 0) seen_rise = 1'b1;
        else busy1++;
      end
      P_DATA = P_DATA + 8'h37;
      parity_enable = ~parity_enable;
    end
    Data_Valid = 1'b0;
    chk("b2b_first_len", busy1, 10);
    chk("b2b_idle_gap", idle_cnt, 1);
    chk("b2b_second_seen", {31'd0, seen_rise}, 32'd1);
    repeat (20) @(negedge clk);

    // Reset in the middle of data bit 4 of 0x0F (a zero bit).
    @(negedge clk);
    P_DATA = 8'h0F; parity_enable = 1'b1; par_odd = 1'b0; Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_bit4_tx", {31'd0, TX_OUT}, 32'd0);
    chk("pre_rst_bit4_busy", {31'd0, Busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", {31'd0, TX_OUT}, 32'd1);
    chk("async_rst_busy", {31'd0, Busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_frame("55_after_rst", 8'h55, 1'b1, 1'b0, 11, 16'b01010101001);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
